// File: rtl/cmd_fetch_if.sv
// Fetcher <-> memory/decoder/host bundle: read port, command handshake, control and status.
// master = cmd_fetch; slave = the memory/decoder/host side.
interface cmd_fetch_if #(
  parameter int CMD_WIDTH  = 128,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] read_address;
  logic [CMD_WIDTH-1:0]  cmd_in;
  logic [CMD_WIDTH-1:0]  cmd_out;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  jump_en;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic                  stop;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  cmd_count;

  modport master (
    input  start, start_addr, cmd_in, cmd_ready, jump_en, jump_addr, stop,
    output read_address, cmd_out, cmd_addr, cmd_valid, busy, cmd_count
  );

  modport slave (
    output start, start_addr, cmd_in, cmd_ready, jump_en, jump_addr, stop,
    input  read_address, cmd_out, cmd_addr, cmd_valid, busy, cmd_count
  );
endinterface

// File: rtl/cmd_fetch.sv
// Command fetch sequencer: one command per cycle from a 1-cycle registered-address memory.
// Latency start->valid 1 cycle; on stall the current address is re-read so cmd_out holds.
module cmd_fetch #(
  parameter int CMD_WIDTH  = 128,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  cmd_fetch_if.master  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CNT_WIDTH-1:0]  cmd_count;
  logic                  accept;

  assign accept    = (state == RUN) & bus.cmd_ready;
  assign next_addr = bus.jump_en ? bus.jump_addr : cur_addr + ADDR_WIDTH'(1);

  // The address presented now is the word seen on cmd_in next cycle, so it
  // must already reflect this cycle's accept to avoid a bubble.
  always_comb begin
    rd_addr = cur_addr;
    case (state)
      IDLE: if (bus.start && reset_n) rd_addr = bus.start_addr;
      RUN:  if (accept && !bus.stop)  rd_addr = next_addr;
      default: rd_addr = cur_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      cmd_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cur_addr <= bus.start_addr;
            state    <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            cmd_count <= cmd_count + CNT_WIDTH'(1);
            if (bus.stop) state    <= IDLE;
            else          cur_addr <= next_addr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.read_address = rd_addr;
  assign bus.cmd_out      = bus.cmd_in;
  assign bus.cmd_addr     = cur_addr;
  assign bus.cmd_valid    = (state == RUN);
  assign bus.busy         = (state == RUN);
  assign bus.cmd_count    = cmd_count;

endmodule
